c_selector_n: RTL and testbench

// - Clocked, parametrised successor of the 5-way selector: routes one input token (data + per-channel

---
 rtl/c_selector_n_pkg.sv | 17 +
 rtl/c_selector_n_rr_pick.sv | 42 ++++
 rtl/c_selector_n.sv | 120 ++++++++++++
 tb/tb_c_selector_n.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/c_selector_n_pkg.sv
// rtl/c_selector_n_pkg.sv - shared mode constants and helpers for the selector family
//
// Purpose : mode encodings shared by all selector variants and their benches,
//           plus a small wrap-around increment helper for round-robin pointers.
// Ports   : none (package).

package c_selector_n_pkg;

    localparam int SEL_MODE_MULTICAST = 0;
    localparam int SEL_MODE_ANYCAST   = 1;

    // Increment an index and wrap it back to zero at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/c_selector_n_rr_pick.sv
// rtl/c_selector_n_rr_pick.sv - combinational rotate-priority one-hot picker
//
// Purpose : grants the first set request bit at or after i_ptr, wrapping from
//           N-1 back to 0. Produces both the one-hot grant and its index.
// Ports   : i_req   [N]          request vector
//           i_ptr   [$clog2(N)]  position with highest priority this cycle
//           o_grant [N]          one-hot grant, zero when no request is set
//           o_idx   [$clog2(N)]  index of the granted bit (0 when none)

module rr_onehot_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int W = $clog2(N);

    int   pos;
    logic found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        pos     = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(i_ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && i_req[W'(pos)]) begin
                found            = 1'b1;
                o_grant[W'(pos)] = 1'b1;
                o_idx            = W'(pos);
            end
        end
    end

endmodule

// File: rtl/c_selector_n.sv
// rtl/c_selector_n.sv - clocked token selector routing one input to NUM_CH channels
//
// Purpose : accepts a token (payload + channel mask) and presents it on the
//           masked output channels, each with its own valid/ready handshake.
//           MULTICAST targets every masked channel; ANYCAST targets exactly one,
//           chosen round-robin. Tokens with an empty mask are consumed and counted.
// Ports   : clk, rst      clock, asynchronous active-high reset
//           i_valid/o_ready/i_data    input token ({mask, payload})
//           o_valid/i_ready/o_data    per-channel outputs (channel k at k*DATA_WIDTH)
//           o_busy                    holding stage occupied
//           o_drop_cnt                saturating count of empty-mask tokens

module c_selector_n
    import c_selector_n_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 5,
    parameter int MODE       = 0,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [DATA_WIDTH+NUM_CH-1:0]   i_data,
    output logic [NUM_CH-1:0]              o_valid,
    input  logic [NUM_CH-1:0]              i_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   o_data,
    output logic                           o_busy,
    output logic [CNT_W-1:0]               o_drop_cnt
);

    localparam int PTR_W = $clog2(NUM_CH);

    logic [DATA_WIDTH-1:0] r_data;
    logic [NUM_CH-1:0]     r_pend;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]      r_drop_cnt;

    logic [NUM_CH-1:0]     mask;
    logic [DATA_WIDTH-1:0] payload;
    logic                  done;
    logic                  accept;
    logic [NUM_CH-1:0]     load_pend;
    logic [PTR_W-1:0]      next_ptr;

    assign mask    = i_data[DATA_WIDTH +: NUM_CH];
    assign payload = i_data[DATA_WIDTH-1:0];

    // The stage can take a new token when every still-pending channel
    // completes this cycle; this keeps one token per clock at full rate.
    assign done    = ((r_pend & ~i_ready) == '0);
    assign o_ready = done;
    assign accept  = i_valid & done;

    generate
        if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_ch
            $error("c_selector_n: NUM_CH must be in 2..16");
        end

        if (MODE == SEL_MODE_ANYCAST) begin : g_any
            logic [NUM_CH-1:0] grant;
            logic [PTR_W-1:0]  win_idx;

            rr_onehot_pick #(
                .N (NUM_CH)
            ) u_pick (
                .i_req   (mask),
                .i_ptr   (r_rr_ptr),
                .o_grant (grant),
                .o_idx   (win_idx)
            );

            assign load_pend = grant;
            // Next search starts just past the winner so ties rotate fairly.
            assign next_ptr  = PTR_W'(wrap_inc(int'(win_idx), NUM_CH));
        end else if (MODE == SEL_MODE_MULTICAST) begin : g_multi
            assign load_pend = mask;
            assign next_ptr  = r_rr_ptr;
        end else begin : g_bad_mode
            $error("c_selector_n: MODE must be 0 (MULTICAST) or 1 (ANYCAST)");
            assign load_pend = mask;
            assign next_ptr  = r_rr_ptr;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_pend     <= '0;
            r_rr_ptr   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (accept && (mask != '0)) begin
                // A load overrides any completion in the same cycle; accept
                // already guarantees every old pending channel is finishing.
                r_data   <= payload;
                r_pend   <= load_pend;
                r_rr_ptr <= next_ptr;
            end else begin
                r_pend <= r_pend & ~i_ready;
                if (accept && (r_drop_cnt != {CNT_W{1'b1}})) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_out
            assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = r_data & {DATA_WIDTH{r_pend[k]}};
        end
    endgenerate

    assign o_valid    = r_pend;
    assign o_busy     = |r_pend;
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_c_selector_n.sv
// tb/tb_c_selector_n.sv - self-checking bench for c_selector_n (multicast and anycast)

module tb_c_selector_n;

    logic         clk;
    logic         rst;

    logic         mc_valid, mc_ready, mc_busy;
    logic [36:0]  mc_data;
    logic [4:0]   mc_ovalid, mc_iready;
    logic [159:0] mc_odata;
    logic [1:0]   mc_drop;

    logic         ac_valid, ac_ready, ac_busy;
    logic [36:0]  ac_data;
    logic [4:0]   ac_ovalid, ac_iready;
    logic [159:0] ac_odata;
    logic [15:0]  ac_drop;

    c_selector_n #(.DATA_WIDTH(32), .NUM_CH(5), .MODE(0), .CNT_W(2)) u_mc (
        .clk(clk), .rst(rst), .i_valid(mc_valid), .o_ready(mc_ready), .i_data(mc_data),
        .o_valid(mc_ovalid), .i_ready(mc_iready), .o_data(mc_odata), .o_busy(mc_busy),
        .o_drop_cnt(mc_drop));

    c_selector_n #(.DATA_WIDTH(32), .NUM_CH(5), .MODE(1), .CNT_W(16)) u_ac (
        .clk(clk), .rst(rst), .i_valid(ac_valid), .o_ready(ac_ready), .i_data(ac_data),
        .o_valid(ac_ovalid), .i_ready(ac_iready), .o_data(ac_odata), .o_busy(ac_busy),
        .o_drop_cnt(ac_drop));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: index 0 = multicast instance, 1 = anycast instance.
    logic [4:0]  m_pend [2];
    logic [31:0] m_data [2];
    int          m_ptr  [2];
    int          m_drop [2];
    int          drop_max [2] = '{3, 65535};

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0; m_data[d] = '0; m_ptr[d] = 0; m_drop[d] = 0;
        end
    endtask

    // Compare one instance against the model for the inputs currently driven,
    // then advance the model by one clock.
    task automatic check_dut(input int d);
        logic [4:0]   ov, msk, rdy;
        logic [159:0] od, exp_od;
        logic         ordy, busy, iv, exp_rdy, found;
        logic [31:0]  pay;
        int           drop, c;
        string        nm;
        if (d == 0) begin
            ov = mc_ovalid; od = mc_odata; ordy = mc_ready; busy = mc_busy; drop = int'(mc_drop);
            iv = mc_valid; msk = mc_data[36:32]; pay = mc_data[31:0]; rdy = mc_iready; nm = "mc";
        end else begin
            ov = ac_ovalid; od = ac_odata; ordy = ac_ready; busy = ac_busy; drop = int'(ac_drop);
            iv = ac_valid; msk = ac_data[36:32]; pay = ac_data[31:0]; rdy = ac_iready; nm = "ac";
        end
        exp_rdy = 1'b1;
        exp_od  = '0;
        for (int k = 0; k < 5; k++) begin
            if (m_pend[d][k]) begin
                exp_od[k*32 +: 32] = m_data[d];
                if (!rdy[k]) exp_rdy = 1'b0;
            end
        end
        check({nm, " o_valid"},    160'(ov),   160'(m_pend[d]));
        check({nm, " o_data"},     od,         exp_od);
        check({nm, " o_ready"},    160'(ordy), 160'(exp_rdy));
        check({nm, " o_busy"},     160'(busy), 160'(m_pend[d] != 0));
        check({nm, " o_drop_cnt"}, 160'(drop), 160'(m_drop[d]));
        m_pend[d] = m_pend[d] & ~rdy;
        if (iv && exp_rdy) begin
            if (msk == 0) begin
                if (m_drop[d] < drop_max[d]) m_drop[d]++;
            end else begin
                m_data[d] = pay;
                if (d == 0) begin
                    m_pend[d] = msk;
                end else begin
                    found = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        c = (m_ptr[d] + i) % 5;
                        if (!found && ((msk >> c) & 5'd1) != 0) begin
                            found = 1'b1;
                            m_pend[d] = 5'd1 << c;
                            m_ptr[d]  = (c + 1) % 5;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mc_valid = 0; mc_data = '0; mc_iready = 5'h1f;
        ac_valid = 0; ac_data = '0; ac_iready = 5'h1f;
    endtask

    logic [4:0] stag_rdy  [4] = '{5'b00000, 5'b00001, 5'b10000, 5'b00100};
    logic [4:0] stag_ov   [4] = '{5'b10101, 5'b10101, 5'b10100, 5'b00100};
    logic       stag_ordy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         any_tgt   [6] = '{0, 1, 3, 0, 1, 3};
    int         drop_exp  [5] = '{1, 2, 3, 3, 3};

    initial begin
        logic [31:0] pay;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset o_valid", 160'(mc_ovalid), 160'(0));
        check("reset o_ready", 160'(mc_ready), 160'(1));
        rst = 1'b0;
        @(negedge clk);

        // Multicast staggered completion.
        mc_valid = 1; mc_data = {5'b10101, 32'hDEADBEEF}; mc_iready = 5'b00000;
        step();
        mc_valid = 0;
        for (int s = 0; s < 4; s++) begin
            mc_iready = stag_rdy[s];
            #1;
            check("stag o_valid", 160'(mc_ovalid), 160'(stag_ov[s]));
            check("stag o_ready", 160'(mc_ready), 160'(stag_ordy[s]));
            check("stag ch1/ch3 zero", 160'({mc_odata[32 +: 32], mc_odata[96 +: 32]}), 160'(0));
            step();
        end
        check("stag final o_valid", 160'(mc_ovalid), 160'(0));

        // Back-to-back full rate, payload order and 1-cycle latency.
        mc_iready = 5'b11111;
        for (int t = 0; t < 8; t++) begin
            pay = 32'hA000_0000 + 32'(t);
            mc_valid = 1; mc_data = {5'b11111, pay};
            #1 check("b2b o_ready", 160'(mc_ready), 160'(1));
            step();
            check("b2b ch0", 160'(mc_odata[31:0]), 160'(pay));
            check("b2b ch4", 160'(mc_odata[159:128]), 160'(pay));
        end
        mc_valid = 0;
        step();

        // Anycast round-robin with a stall on channel 1.
        for (int t = 0; t < 6; t++) begin
            ac_valid = 1; ac_data = {5'b01011, 32'h100 + 32'(t)}; ac_iready = 5'b11111;
            step();
            check("any target", 160'(ac_ovalid), 160'(5'd1 << any_tgt[t]));
            if (t == 1) begin
                ac_data = {5'b01011, 32'h102}; ac_iready = 5'b11101;
                for (int h = 0; h < 2; h++) begin
                    #1 check("any stall ready", 160'(ac_ready), 160'(0));
                    step();
                    check("any stall hold", 160'(ac_ovalid), 160'(5'b00010));
                end
            end
        end
        ac_valid = 0; ac_iready = 5'b11111;
        step();

        // Drop counter saturation on the CNT_W=2 instance.
        for (int t = 0; t < 5; t++) begin
            mc_valid = 1; mc_data = {5'b00000, 32'h5555_0000 + 32'(t)}; mc_iready = 5'b00000;
            step();
            check("drop cnt", 160'(mc_drop), 160'(drop_exp[t]));
            check("drop o_valid", 160'(mc_ovalid), 160'(0));
        end

        // Load and completion in the same cycle.
        mc_valid = 1; mc_data = {5'b00001, 32'h1111_1111}; mc_iready = 5'b00000;
        step();
        mc_valid = 1; mc_data = {5'b00110, 32'h2222_2222}; mc_iready = 5'b00001;
        #1 check("ovl o_ready", 160'(mc_ready), 160'(1));
        step();
        check("ovl o_valid", 160'(mc_ovalid), 160'(5'b00110));
        check("ovl ch1 data", 160'(mc_odata[63:32]), 160'(32'h2222_2222));
        mc_valid = 0; mc_iready = 5'b11111;
        step();

        // Reset in the middle of a transfer.
        mc_valid = 1; mc_data = {5'b10110, 32'hCAFE_F00D}; mc_iready = 5'b00000;
        step();
        mc_valid = 0;
        #1 check("pre-rst o_valid", 160'(mc_ovalid), 160'(5'b10110));
        rst = 1'b1;
        #1;
        check("rst o_valid", 160'(mc_ovalid), 160'(0));
        check("rst o_data", mc_odata, 160'(0));
        check("rst o_ready", 160'(mc_ready), 160'(1));
        check("rst o_drop_cnt", 160'(mc_drop), 160'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        mc_iready = 5'b11111;
        for (int t = 0; t < 3; t++) begin
            step();
            check("post-rst no stale", 160'(mc_ovalid), 160'(0));
        end

        // Randomized traffic against the reference model.
        for (int t = 0; t < 400; t++) begin
            mc_valid  = ($urandom_range(3) != 0);
            mc_data   = {(($urandom_range(7) == 0) ? 5'b0 : 5'($urandom)), 32'($urandom)};
            mc_iready = 5'($urandom) | 5'($urandom);
            ac_valid  = ($urandom_range(3) != 0);
            ac_data   = {(($urandom_range(7) == 0) ? 5'b0 : 5'($urandom)), 32'($urandom)};
            ac_iready = 5'($urandom) | 5'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
